// File: rtl/midi_msg_receiver_if.sv
// ---------------------------------------------------------------------------
// midi_msg_receiver_if
//   Bundles the MIDI serial input with everything the receiver reports:
//   deframed bytes, framing errors, assembled channel-voice messages, the
//   LED display value and the deframer state for observation.
//
//   Handshake: BYTE_VALID, FRAME_ERR and MSG_VALID are single-cycle,
//   valid-only pulses with no ready/back-pressure. The matching data
//   (BYTE, MSG_*, LED) is valid in the pulse cycle and holds until the
//   next event, so a consumer may sample it at any later time.
//
//   Modports
//     master : the receiver (reads DATA, drives all outputs)
//     slave  : the consumer/driver side (drives DATA, reads outputs)
//
//   Signals
//     DATA        serial line, idle high
//     BYTE_VALID  1-cycle pulse, BYTE holds a new good byte
//     BYTE        last good received byte
//     FRAME_ERR   1-cycle pulse, stop bit sampled low
//     MSG_VALID   1-cycle pulse, MSG_* hold a complete accepted message
//     MSG_STATUS  status byte of the message (running status included)
//     MSG_DATA1   first data byte
//     MSG_DATA2   second data byte, 0 for single-data-byte messages
//     LED         display value
//     STATE_DBG   deframer FSM state (0 idle,1 start,2 data,3 stop,4 break)
// ---------------------------------------------------------------------------
interface midi_msg_receiver_if;
    logic       DATA;
    logic       BYTE_VALID;
    logic [7:0] BYTE;
    logic       FRAME_ERR;
    logic       MSG_VALID;
    logic [7:0] MSG_STATUS;
    logic [7:0] MSG_DATA1;
    logic [7:0] MSG_DATA2;
    logic [7:0] LED;
    logic [2:0] STATE_DBG;

    modport master (
        input  DATA,
        output BYTE_VALID, BYTE, FRAME_ERR,
        output MSG_VALID, MSG_STATUS, MSG_DATA1, MSG_DATA2,
        output LED, STATE_DBG
    );

    modport slave (
        output DATA,
        input  BYTE_VALID, BYTE, FRAME_ERR,
        input  MSG_VALID, MSG_STATUS, MSG_DATA1, MSG_DATA2,
        input  LED, STATE_DBG
    );
endinterface

// File: rtl/midi_msg_receiver.sv
// ---------------------------------------------------------------------------
// midi_msg_receiver
//   Oversampled 8N1 MIDI byte deframer followed by a channel-voice message
//   assembler with running status. Drives an 8-bit LED display value and
//   reports complete messages to downstream logic.
//
//   Parameters
//     OVERSAMPLE  clocks per bit period (even, >= 8)
//     CNT_W       bit-timer width, 2**CNT_W >= OVERSAMPLE
//     OMNI        1: accept every channel, 0: only CHANNEL
//     CHANNEL     accepted channel when OMNI = 0
//     LED_MODE    0: LED = held note number, 1: LED = last velocity
//
//   Ports
//     CLK    system clock
//     RESET  asynchronous active-low reset
//     bus    midi_msg_receiver_if.master (DATA in, byte/message/LED out)
// ---------------------------------------------------------------------------
module midi_msg_receiver #(
    parameter int OVERSAMPLE = 128,
    parameter int CNT_W      = 7,
    parameter int OMNI       = 1,
    parameter int CHANNEL    = 0,
    parameter int LED_MODE   = 0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    midi_msg_receiver_if.master    bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    // -----------------------------------------------------------------------
    // Input synchroniser. sync_prev is one stage behind sync2 so that a
    // falling edge is seen as sync_prev=1, sync2=0.
    // -----------------------------------------------------------------------
    logic sync1, sync2, sync_prev;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= bus.DATA;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // -----------------------------------------------------------------------
    // Deframer FSM
    // -----------------------------------------------------------------------
    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       byte_r, byte_n;
    logic             byte_valid_r, byte_valid_n;
    logic             frame_err_r, frame_err_n;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            timer        <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            byte_r       <= '0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            shreg        <= shreg_n;
            bit_cnt      <= bit_cnt_n;
            byte_r       <= byte_n;
            byte_valid_r <= byte_valid_n;
            frame_err_r  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        // Free-running bit timer, wraps at OVERSAMPLE-1. In DATA/STOP the
        // wrap point is the mid-bit sample because START cleared it there.
        timer_n      = (timer == FULL_M1) ? '0 : timer + CNT_W'(1);
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        byte_n       = byte_r;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_n = '0;
                if (sync_prev && !sync2) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (timer == HALF_M1) begin
                    if (sync2) begin
                        // Line back high at mid start bit: glitch.
                        state_n = ST_IDLE;
                    end else begin
                        timer_n   = '0;
                        bit_cnt_n = '0;
                        state_n   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (timer == FULL_M1) begin
                    shreg_n   = {sync2, shreg[7:1]};   // LSB first
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (timer == FULL_M1) begin
                    if (sync2) begin
                        byte_n       = shreg;
                        byte_valid_n = 1'b1;
                        state_n      = ST_IDLE;
                    end else begin
                        frame_err_n  = 1'b1;
                        state_n      = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Stay here while the line is held low so a long break
                // cannot be mistaken for a stream of start bits.
                timer_n = '0;
                if (sync2) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Message assembler, acts on each BYTE_VALID pulse.
    // run_st = 0 means "no running status": every real status has bit 7 set.
    // -----------------------------------------------------------------------
    logic [7:0] run_st, run_st_n;
    logic       idx, idx_n;
    logic [7:0] d1_hold, d1_hold_n;
    logic       msg_valid_r, msg_valid_n;
    logic [7:0] msg_status_r, msg_status_n;
    logic [7:0] msg_d1_r, msg_d1_n;
    logic [7:0] msg_d2_r, msg_d2_n;
    logic [7:0] led_r, led_n;

    logic       complete;
    logic [7:0] c_d1, c_d2;
    logic       one_byte;
    logic       accept;
    logic       is_note_on, is_note_off, is_note;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            run_st       <= '0;
            idx          <= 1'b0;
            d1_hold      <= '0;
            msg_valid_r  <= 1'b0;
            msg_status_r <= '0;
            msg_d1_r     <= '0;
            msg_d2_r     <= '0;
            led_r        <= '0;
        end else begin
            run_st       <= run_st_n;
            idx          <= idx_n;
            d1_hold      <= d1_hold_n;
            msg_valid_r  <= msg_valid_n;
            msg_status_r <= msg_status_n;
            msg_d1_r     <= msg_d1_n;
            msg_d2_r     <= msg_d2_n;
            led_r        <= led_n;
        end
    end

    always_comb begin
        run_st_n     = run_st;
        idx_n        = idx;
        d1_hold_n    = d1_hold;
        msg_valid_n  = 1'b0;
        msg_status_n = msg_status_r;
        msg_d1_n     = msg_d1_r;
        msg_d2_n     = msg_d2_r;
        led_n        = led_r;
        complete     = 1'b0;
        c_d1         = '0;
        c_d2         = '0;

        // Program change and channel pressure carry a single data byte.
        one_byte = (run_st[7:4] == 4'hC) || (run_st[7:4] == 4'hD);
        accept   = (OMNI != 0) || (run_st[3:0] == 4'(CHANNEL));

        if (byte_valid_r) begin
            if (byte_r >= 8'hF8) begin
                // Realtime: transparent, even inside a message.
            end else if (byte_r >= 8'hF0) begin
                run_st_n = '0;
                idx_n    = 1'b0;
            end else if (byte_r[7]) begin
                run_st_n = byte_r;
                idx_n    = 1'b0;
            end else if (run_st != 8'h00) begin
                if (!idx) begin
                    if (one_byte) begin
                        complete = 1'b1;
                        c_d1     = byte_r;
                    end else begin
                        d1_hold_n = byte_r;
                        idx_n     = 1'b1;
                    end
                end else begin
                    complete = 1'b1;
                    c_d1     = d1_hold;
                    c_d2     = byte_r;
                    idx_n    = 1'b0;
                end
            end
        end

        is_note_on  = (run_st[7:4] == 4'h9) && (c_d2 != 8'h00);
        is_note_off = (run_st[7:4] == 4'h8) ||
                      ((run_st[7:4] == 4'h9) && (c_d2 == 8'h00));
        is_note     = (run_st[7:4] == 4'h8) || (run_st[7:4] == 4'h9);

        // Filtered-channel messages are assembled (index advances and
        // resets) but leave MSG_* and LED exactly as they were.
        if (complete && accept) begin
            msg_valid_n  = 1'b1;
            msg_status_n = run_st;
            msg_d1_n     = c_d1;
            msg_d2_n     = c_d2;
            if (LED_MODE == 0) begin
                if (is_note_on) begin
                    led_n = c_d1;
                end else if (is_note_off && (c_d1 == led_r)) begin
                    led_n = 8'h00;
                end
            end else begin
                if (is_note) begin
                    led_n = c_d2;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.BYTE_VALID = byte_valid_r;
    assign bus.BYTE       = byte_r;
    assign bus.FRAME_ERR  = frame_err_r;
    assign bus.MSG_VALID  = msg_valid_r;
    assign bus.MSG_STATUS = msg_status_r;
    assign bus.MSG_DATA1  = msg_d1_r;
    assign bus.MSG_DATA2  = msg_d2_r;
    assign bus.LED        = led_r;
    assign bus.STATE_DBG  = state;

endmodule

// File: tb/tb_midi_msg_receiver.sv
// ---------------------------------------------------------------------------
// tb_midi_msg_receiver
//   Two receivers: u_a at 128 clk/bit, omni, LED = note; u_b at 16 clk/bit,
//   channel 1 only, LED = velocity. Byte tables give the byte to send, the
//   message it should complete (if any) and the LED value afterwards;
//   hand-written sequences cover glitch, framing error/break and reset.
// ---------------------------------------------------------------------------
module tb_midi_msg_receiver;

    typedef struct packed {
        logic [7:0]  b;
        logic        m;
        logic [23:0] msg;
        logic [7:0]  led;
    } vec_t;

    logic clk;
    logic rst_n;

    midi_msg_receiver_if bus_a ();
    midi_msg_receiver_if bus_b ();

    midi_msg_receiver #(
        .OVERSAMPLE(128), .CNT_W(7), .OMNI(1), .CHANNEL(0), .LED_MODE(0)
    ) u_a (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus_a.master)
    );

    midi_msg_receiver #(
        .OVERSAMPLE(16), .CNT_W(4), .OMNI(0), .CHANNEL(1), .LED_MODE(1)
    ) u_b (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus_b.master)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int bv_cnt [2];
    int fe_cnt [2];
    int mv_cnt [2];
    logic [23:0] exp_q_a[$];
    logic [23:0] exp_q_b[$];

    vec_t tab_a  [22];
    vec_t tab_a2 [4];
    vec_t tab_b  [16];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            bv_cnt[i] = 0;
            fe_cnt[i] = 0;
            mv_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (bus_a.BYTE_VALID) bv_cnt[0]++;
        if (bus_a.FRAME_ERR)  fe_cnt[0]++;
        if (bus_b.BYTE_VALID) bv_cnt[1]++;
        if (bus_b.FRAME_ERR)  fe_cnt[1]++;
        if (bus_a.MSG_VALID) begin
            mv_cnt[0]++;
            total++;
            if (exp_q_a.size() == 0) begin
                bad++;
                $display("FAIL msg_a: got %02h/%02h/%02h expected none",
                         bus_a.MSG_STATUS, bus_a.MSG_DATA1, bus_a.MSG_DATA2);
            end else begin
                e = exp_q_a.pop_front();
                if ({bus_a.MSG_STATUS, bus_a.MSG_DATA1, bus_a.MSG_DATA2} !== e) begin
                    bad++;
                    $display("FAIL msg_a: got %02h/%02h/%02h expected %06h",
                             bus_a.MSG_STATUS, bus_a.MSG_DATA1, bus_a.MSG_DATA2, e);
                end
            end
        end
        if (bus_b.MSG_VALID) begin
            mv_cnt[1]++;
            total++;
            if (exp_q_b.size() == 0) begin
                bad++;
                $display("FAIL msg_b: got %02h/%02h/%02h expected none",
                         bus_b.MSG_STATUS, bus_b.MSG_DATA1, bus_b.MSG_DATA2);
            end else begin
                e = exp_q_b.pop_front();
                if ({bus_b.MSG_STATUS, bus_b.MSG_DATA1, bus_b.MSG_DATA2} !== e) begin
                    bad++;
                    $display("FAIL msg_b: got %02h/%02h/%02h expected %06h",
                             bus_b.MSG_STATUS, bus_b.MSG_DATA1, bus_b.MSG_DATA2, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_line(input int d, input logic v);
        if (d == 0) bus_a.DATA = v;
        else        bus_b.DATA = v;
    endtask

    function automatic logic [7:0] get_byte(input int d);
        return (d == 0) ? bus_a.BYTE : bus_b.BYTE;
    endfunction

    function automatic logic [7:0] get_led(input int d);
        return (d == 0) ? bus_a.LED : bus_b.LED;
    endfunction

    // Sends one frame; the line is left at the stop-bit level afterwards,
    // so stop = 0 models a break that stays low.
    task automatic send_frame(input int d, input logic [7:0] b, input logic stop);
        int os;
        os = (d == 0) ? 128 : 16;
        set_line(d, 1'b0);
        repeat (os) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(d, b[i]);
            repeat (os) @(negedge clk);
        end
        set_line(d, stop);
        repeat (os) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic apply(input int d, input vec_t v);
        int bv0, mv0;
        bv0 = bv_cnt[d];
        mv0 = mv_cnt[d];
        if (v.m) begin
            if (d == 0) exp_q_a.push_back(v.msg);
            else        exp_q_b.push_back(v.msg);
        end
        send_frame(d, v.b, 1'b1);
        check("byte_valid_count", 64'(bv_cnt[d] - bv0), 64'd1);
        check("byte", 64'(get_byte(d)), 64'(v.b));
        check("msg_valid_count", 64'(mv_cnt[d] - mv0), 64'(v.m));
        check("led", 64'(get_led(d)), 64'(v.led));
    endtask

    // ---------------- test ----------------
    initial begin
        int bv0, fe0;

        // Byte, message completes?, expected message, LED afterwards.
        tab_a[0]  = '{8'h90, 1'b0, 24'h000000, 8'h00};
        tab_a[1]  = '{8'h3C, 1'b0, 24'h000000, 8'h00};
        tab_a[2]  = '{8'h64, 1'b1, 24'h903C64, 8'h3C};
        tab_a[3]  = '{8'h3C, 1'b0, 24'h000000, 8'h3C};
        tab_a[4]  = '{8'h00, 1'b1, 24'h903C00, 8'h00};
        tab_a[5]  = '{8'hC5, 1'b0, 24'h000000, 8'h00};
        tab_a[6]  = '{8'h07, 1'b1, 24'hC50700, 8'h00};
        tab_a[7]  = '{8'h90, 1'b0, 24'h000000, 8'h00};
        tab_a[8]  = '{8'h40, 1'b0, 24'h000000, 8'h00};
        tab_a[9]  = '{8'hF8, 1'b0, 24'h000000, 8'h00};
        tab_a[10] = '{8'h50, 1'b1, 24'h904050, 8'h40};
        tab_a[11] = '{8'hF2, 1'b0, 24'h000000, 8'h40};
        tab_a[12] = '{8'h10, 1'b0, 24'h000000, 8'h40};
        tab_a[13] = '{8'h80, 1'b0, 24'h000000, 8'h40};
        tab_a[14] = '{8'h40, 1'b0, 24'h000000, 8'h40};
        tab_a[15] = '{8'h00, 1'b1, 24'h804000, 8'h00};
        tab_a[16] = '{8'h90, 1'b0, 24'h000000, 8'h00};
        tab_a[17] = '{8'h30, 1'b0, 24'h000000, 8'h00};
        tab_a[18] = '{8'h7F, 1'b1, 24'h90307F, 8'h30};
        tab_a[19] = '{8'h80, 1'b0, 24'h000000, 8'h30};
        tab_a[20] = '{8'h31, 1'b0, 24'h000000, 8'h30};
        tab_a[21] = '{8'h00, 1'b1, 24'h803100, 8'h30};

        // After reset: running status is gone, so a lone data byte is dropped.
        tab_a2[0] = '{8'h3C, 1'b0, 24'h000000, 8'h00};
        tab_a2[1] = '{8'h91, 1'b0, 24'h000000, 8'h00};
        tab_a2[2] = '{8'h22, 1'b0, 24'h000000, 8'h00};
        tab_a2[3] = '{8'h33, 1'b1, 24'h912233, 8'h22};

        // Channel 1 only, LED = velocity.
        tab_b[0]  = '{8'h90, 1'b0, 24'h000000, 8'h00};
        tab_b[1]  = '{8'h3C, 1'b0, 24'h000000, 8'h00};
        tab_b[2]  = '{8'h64, 1'b0, 24'h000000, 8'h00};
        tab_b[3]  = '{8'h91, 1'b0, 24'h000000, 8'h00};
        tab_b[4]  = '{8'h3C, 1'b0, 24'h000000, 8'h00};
        tab_b[5]  = '{8'h64, 1'b1, 24'h913C64, 8'h64};
        tab_b[6]  = '{8'h81, 1'b0, 24'h000000, 8'h64};
        tab_b[7]  = '{8'h3C, 1'b0, 24'h000000, 8'h64};
        tab_b[8]  = '{8'h10, 1'b1, 24'h813C10, 8'h10};
        tab_b[9]  = '{8'hC1, 1'b0, 24'h000000, 8'h10};
        tab_b[10] = '{8'h05, 1'b1, 24'hC10500, 8'h10};
        tab_b[11] = '{8'hD1, 1'b0, 24'h000000, 8'h10};
        tab_b[12] = '{8'h7F, 1'b1, 24'hD17F00, 8'h10};
        tab_b[13] = '{8'h92, 1'b0, 24'h000000, 8'h10};
        tab_b[14] = '{8'h01, 1'b0, 24'h000000, 8'h10};
        tab_b[15] = '{8'h02, 1'b0, 24'h000000, 8'h10};

        // Reset
        rst_n      = 1'b1;
        bus_a.DATA = 1'b1;
        bus_b.DATA = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_a",
              {21'd0, bus_a.BYTE_VALID, bus_a.BYTE, bus_a.FRAME_ERR, bus_a.MSG_VALID,
               bus_a.MSG_STATUS, bus_a.MSG_DATA1, bus_a.MSG_DATA2, bus_a.LED}, 64'd0);
        check("reset_outputs_b",
              {21'd0, bus_b.BYTE_VALID, bus_b.BYTE, bus_b.FRAME_ERR, bus_b.MSG_VALID,
               bus_b.MSG_STATUS, bus_b.MSG_DATA1, bus_b.MSG_DATA2, bus_b.LED}, 64'd0);
        check("reset_state_a", 64'(bus_a.STATE_DBG), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Main table at 128 clk/bit
        for (int i = 0; i < 22; i++) apply(0, tab_a[i]);

        // Low glitch of 40 clocks
        bv0 = bv_cnt[0];
        set_line(0, 1'b0);
        repeat (20) @(negedge clk);
        check("glitch_in_start", 64'(bus_a.STATE_DBG), 64'd1);
        repeat (20) @(negedge clk);
        set_line(0, 1'b1);
        repeat (100) @(negedge clk);
        check("glitch_no_byte", 64'(bv_cnt[0] - bv0), 64'd0);
        check("glitch_back_idle", 64'(bus_a.STATE_DBG), 64'd0);

        // Stop bit low, then line held low
        bv0 = bv_cnt[0];
        fe0 = fe_cnt[0];
        send_frame(0, 8'h55, 1'b0);
        check("ferr_once", 64'(fe_cnt[0] - fe0), 64'd1);
        check("ferr_no_byte", 64'(bv_cnt[0] - bv0), 64'd0);
        check("ferr_byte_kept", 64'(bus_a.BYTE), 64'h00);
        check("ferr_in_break", 64'(bus_a.STATE_DBG), 64'd4);
        repeat (5000) @(negedge clk);
        check("break_no_more_ferr", 64'(fe_cnt[0] - fe0), 64'd1);
        check("break_no_byte", 64'(bv_cnt[0] - bv0), 64'd0);
        check("break_still", 64'(bus_a.STATE_DBG), 64'd4);
        set_line(0, 1'b1);
        repeat (10) @(negedge clk);
        check("break_released_idle", 64'(bus_a.STATE_DBG), 64'd0);
        apply(0, '{8'hF8, 1'b0, 24'h000000, 8'h30});

        // Reset during data bit 4 of 0x3C
        set_line(0, 1'b0);
        repeat (128) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            set_line(0, (i == 2 || i == 3 || i == 4) ? 1'b1 : 1'b0);
            repeat (128) @(negedge clk);
        end
        check("pre_reset_in_data", 64'(bus_a.STATE_DBG), 64'd2);
        rst_n = 1'b0;
        set_line(0, 1'b1);
        repeat (2) @(negedge clk);
        check("midframe_reset_outputs",
              {21'd0, bus_a.BYTE_VALID, bus_a.BYTE, bus_a.FRAME_ERR, bus_a.MSG_VALID,
               bus_a.MSG_STATUS, bus_a.MSG_DATA1, bus_a.MSG_DATA2, bus_a.LED}, 64'd0);
        check("midframe_reset_state", 64'(bus_a.STATE_DBG), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) apply(0, tab_a2[i]);

        // 16 clk/bit, channel filter, velocity LED
        for (int i = 0; i < 16; i++) apply(1, tab_b[i]);

        repeat (20) @(negedge clk);
        check("exp_q_a_drained", 64'(exp_q_a.size()), 64'd0);
        check("exp_q_b_drained", 64'(exp_q_b.size()), 64'd0);
        check("no_frame_err_b", 64'(fe_cnt[1]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
